// File: rtl/ecg_bank_writer.sv
// ecg_bank_writer: streams ECG samples into a ping-pong sample memory.
// The address MSB selects the bank being filled. A full bank is handed to
// the downstream reader through switch/bank_ready. If the reader still holds
// its previous bank, the writer stalls and counts the samples it drops.
module ecg_bank_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              release_bank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              switch,
  output logic              bank_ready,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W = ADDR_W - 1;
  localparam logic [PTR_W-1:0] PTR_LAST = '1;

  typedef enum logic {FILL, WAIT_REL} state_t;

  state_t           state, state_n;
  logic             fill_bank, fill_bank_n;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic             reader_busy, busy_n;
  logic             switch_n, bank_ready_n;
  logic [15:0]      frame_n, drop_n;
  logic             accept, free, handover;

  // Ready depends only on registered state, so there is no input-to-ready path.
  assign s_ready = (state == FILL);
  assign accept  = s_valid && s_ready;
  // A release arriving with the last word counts as arriving first.
  assign free    = !reader_busy || release_bank;

  // Next-state and bookkeeping decode.
  always_comb begin
    state_n      = state;
    fill_bank_n  = fill_bank;
    wr_ptr_n     = wr_ptr;
    busy_n       = reader_busy;
    switch_n     = switch;
    frame_n      = frame_cnt;
    drop_n       = drop_cnt;
    bank_ready_n = 1'b0;
    handover     = 1'b0;
    case (state)
      FILL: begin
        if (accept && wr_ptr == PTR_LAST) begin
          wr_ptr_n = '0;
          if (free) handover = 1'b1;
          else      state_n  = WAIT_REL;
        end else begin
          if (accept)       wr_ptr_n = wr_ptr + 1'b1;
          if (release_bank) busy_n   = 1'b0;
        end
      end
      WAIT_REL: begin
        if (s_valid && drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
        if (release_bank) begin
          handover = 1'b1;
          state_n  = FILL;
        end
      end
      default: state_n = FILL;
    endcase
    // Handover: the current bank goes downstream and filling moves to the
    // other bank; the reader is now busy with the bank just handed over.
    if (handover) begin
      switch_n     = fill_bank;
      bank_ready_n = 1'b1;
      busy_n       = 1'b1;
      fill_bank_n  = ~fill_bank;
      wr_ptr_n     = '0;
      frame_n      = frame_cnt + 16'd1;
    end
  end

  // State and handover registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      fill_bank   <= 1'b0;
      wr_ptr      <= '0;
      reader_busy <= 1'b0;
      switch      <= 1'b0;
      bank_ready  <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      fill_bank   <= fill_bank_n;
      wr_ptr      <= wr_ptr_n;
      reader_busy <= busy_n;
      switch      <= switch_n;
      bank_ready  <= bank_ready_n;
      frame_cnt   <= frame_n;
      drop_cnt    <= drop_n;
    end
  end

  // Memory write port: one cycle behind the accept; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= {fill_bank, wr_ptr};
        wr_data <= s_data;
      end
    end
  end

endmodule

// File: doc/ecg_bank_writer.md
# ecg_bank_writer

Upstream acquisition stage for the ECG processing chain. Accepts a stream of digitised ECG samples over a valid/ready handshake and writes them into a dual-bank (ping-pong) sample memory, where the bank is selected by the address MSB. When a bank is full it is handed to the downstream address/processing unit: `switch` is driven to that bank and `bank_ready` is pulsed. Filling continues in the other bank. If the downstream unit has not yet released its previous bank, the writer stalls and counts dropped samples.

## Interface
Parameters:
- `DATA_W`, 16, sample width.
- `ADDR_W`, 12, sample-memory address width; MSB = bank select, so bank depth = 2^(ADDR_W-1).

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input sample valid.
- `s_data`  in  DATA_W  input sample.
- `s_ready`  out  1  writer can accept a sample this cycle.
- `release`  in  1  single-cycle pulse from downstream: finished with the handed-over bank.
- `wr_en`  out  1  memory write strobe.
- `wr_addr`  out  ADDR_W  memory write address, {fill_bank, wr_ptr}.
- `wr_data`  out  DATA_W  memory write data.
- `switch`  out  1  bank most recently handed to downstream.
- `bank_ready`  out  1  one-cycle pulse when a bank is handed over.
- `frame_cnt`  out  16  count of banks handed over; wraps at 2^16.
- `drop_cnt`  out  16  count of samples presented while stalled; saturates at 16'hFFFF.

## Operation
- Internal state: `state` ∈ {FILL, WAIT_REL}; `fill_bank` (1 bit); `wr_ptr` (ADDR_W-1 bits); `reader_busy` (1 bit).
- `s_ready = (state == FILL)`. This is decoded from the registered state only, with no combinational path from inputs.
- Accept = `s_valid && s_ready`. On accept:
  - the next cycle has `wr_en=1`, `wr_addr={fill_bank,wr_ptr}` and `wr_data=s_data`;
  - `wr_ptr` increments.
- Last-word accept (`wr_ptr == 2^(ADDR_W-1)-1`) triggers the handover decision. Here `free = !reader_busy || release`.
  - If free, hand over immediately:
    - `switch <= fill_bank`, `bank_ready` pulses, `reader_busy <= 1`;
    - `fill_bank` toggles, `wr_ptr <= 0`, `frame_cnt++`;
    - remain in FILL with no lost cycle.
  - If not free: `wr_ptr <= 0` and go to WAIT_REL.
- WAIT_REL:
  - `s_ready = 0`.
  - Each cycle with `s_valid = 1` increments `drop_cnt` (saturating); the sample is discarded.
  - On `release`, perform the handover as above and return to FILL.
- `release` when `reader_busy = 0` is ignored.
- `release` in FILL with no last-word accept clears `reader_busy`.
- `release` together with a last-word accept is treated as release first: immediate handover, and `reader_busy` stays 1 because it is reassigned to the new bank.
- `wr_en` is 0 in every cycle not following an accept. `wr_addr` and `wr_data` hold their last values when `wr_en = 0`.

## Timing
- Reset values (async assert; release synchronous to `clk`):
  - `state=FILL`, `fill_bank=0`, `wr_ptr=0`, `reader_busy=0`;
  - `s_ready=1`, `wr_en=0`, `wr_addr=0`, `wr_data=0`;
  - `switch=0`, `bank_ready=0`, `frame_cnt=0`, `drop_cnt=0`.
- Reset mid-fill discards the partial bank. The first post-reset sample goes to address 0.
- Write latency: 1 cycle from accept to `wr_en`.
- Handover latency: `switch`, `bank_ready` and `frame_cnt` update in the same cycle as the `wr_en` of the last word of the bank.
- In the WAIT_REL → FILL path, `bank_ready` is asserted in the cycle after `release` is sampled, and `s_ready` rises in that same cycle.
- Sustained throughput: 1 sample/cycle, provided each release arrives before the next bank fills.
- `bank_ready` is never high for two consecutive cycles.

## Test plan
Use `ADDR_W=4` (bank depth 8) and `DATA_W=16`.
1. **Reset values:** assert `rst_n=0` mid-stream → all outputs at their reset values asynchronously; after deassert, the first sample 16'h0A0A is written to `wr_addr=0`.
2. **First bank fill:** 8 back-to-back samples 1..8 → `wr_addr` 0..7 with matching data; in the cycle of the last write, `switch=0`, `bank_ready=1`, `frame_cnt=1`; the next sample goes to `wr_addr=8`.
3. **Stall and drop:** fill bank 1 (8 samples) with no `release` → `s_ready=0`, state WAIT_REL; 5 further valid cycles → `drop_cnt=5`, no `wr_en`; `release` → `bank_ready` next cycle, `switch=1`, `frame_cnt=2`, `s_ready=1`, next write at `wr_addr=0`.
4. **Release on last-word accept:** `release` coincides with the 8th accept → immediate handover, no stall, `s_ready` stays 1, `reader_busy` remains 1.
5. **Spurious release:** `release` pulses with `reader_busy=0` right after reset → no state change, `frame_cnt=0`.
6. **Counters:** force `drop_cnt` to 16'hFFFF and stall further → it holds at 16'hFFFF; 65536 handovers → `frame_cnt` wraps to 0.
